// File: rtl/vec_loader.sv
// vec_loader: collects a stream of BITS-wide elements into an N-element vector
// and issues a one-cycle bank write strobe with the latched destination and the
// element count. Build option: define VEC_LOADER_ZERO_FILL_EN to clear the whole
// vector when a new load starts; by default, elements beyond the new length keep
// their previous contents.
module vec_loader #(
  parameter int unsigned BITS = 8,
  parameter int unsigned N    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      dst_sel,
  input  logic            abort,
  input  logic [BITS-1:0] s_data,
  input  logic            s_valid,
  input  logic            s_last,
  output logic            s_ready,
  output logic [BITS-1:0] out_vec [N],
  output logic [7:0]      out_len,
  output logic [3:0]      out_sel,
  output logic            write,
  output logic            busy,
  output logic            trunc
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_cnt;
  logic [BITS-1:0] r_vec [N];
  logic [7:0]      r_len;
  logic [3:0]      r_sel;
  logic            r_trunc;
  logic            w_accept;
  logic            w_full;
  logic            w_begin;
  logic [IW-1:0]   w_idx;

  // Handshake and status decodes; s_ready depends only on state and abort.
  assign s_ready  = (r_state == LOAD) && !abort;
  assign write    = (r_state == COMMIT);
  assign busy     = (r_state != IDLE);
  assign w_accept = s_valid && s_ready;
  assign w_full   = (r_cnt == 8'(N - 1));
  assign w_begin  = (r_state == IDLE) && start && !write;
  assign w_idx    = r_cnt[IW-1:0];

  assign out_vec  = r_vec;
  assign out_len  = r_len;
  assign out_sel  = r_sel;
  assign trunc    = r_trunc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode: a beat that is last or fills the vector ends the load.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_begin) w_next = LOAD;
      LOAD: begin
        if (abort)
          w_next = IDLE;
        else if (w_accept && (s_last || w_full))
          w_next = COMMIT;
      end
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch destination on start, store beats, record length/trunc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_sel   <= '0;
      r_trunc <= 1'b0;
      for (int unsigned i = 0; i < N; i++) r_vec[i] <= '0;
    end else if (w_begin) begin
      r_sel   <= dst_sel;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
`ifdef VEC_LOADER_ZERO_FILL_EN
      for (int unsigned i = 0; i < N; i++) r_vec[i] <= '0;
`else
`endif
    end else if (w_accept) begin
      r_vec[w_idx] <= s_data;
      r_cnt        <= r_cnt + 8'd1;
      if (s_last) begin
        r_len <= r_cnt + 8'd1;
      end else if (w_full) begin
        r_len   <= 8'(N);
        r_trunc <= 1'b1;
      end
    end
  end

endmodule
